// File: rtl/rv_ctrl_pipeline.sv
// RV32I control path: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// operand forwarding selects and MEM-stage branch/jump resolution.
module rv_ctrl_pipeline (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruct,
  input  logic        brEq,
  input  logic        brLt,
  input  logic [4:0]  MEMrd,
  input  logic [4:0]  WBrd,
  input  logic        jump_taken,
  input  logic [3:0]  hazard_signal,
  output logic        jump_early,
  output logic        branch_early,
  output logic [2:0]  imm_gen_sel,
  output logic [1:0]  Reg_WBSelID,
  output logic [1:0]  Reg_WBSelEX,
  output logic        EXmemRead,
  output logic        branch_signed,
  output logic        ALU_ASel,
  output logic        ALU_BSel,
  output logic [3:0]  ALU_Sel,
  output logic [2:0]  funct3,
  output logic        dmemRW,
  output logic        Reg_WEn,
  output logic [1:0]  Reg_WBSel,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic [1:0]  forwardDmem,
  output logic [1:0]  forwardBranchA,
  output logic [1:0]  forwardBranchB,
  output logic        PCSel,
  output logic        branch_resolved,
  output logic        actual_taken,
  output logic        mispredict
);

  typedef struct packed {
    logic       wen;
    logic [1:0] wbsel;
    logic       dmemrw;
    logic       is_br;
    logic       is_jmp;
    logic [2:0] f3;
    logic       bsign;
    logic       asel;
    logic       bsel;
    logic [3:0] alu;
    logic [1:0] uses;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } idex_t;

  typedef struct packed {
    logic       wen;
    logic [1:0] wbsel;
    logic       dmemrw;
    logic       is_br;
    logic       is_jmp;
    logic [2:0] f3;
    logic       eq;
    logic       lt;
  } exmem_t;

  typedef struct packed {
    logic       wen;
    logic [1:0] wbsel;
  } memwb_t;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic [6:0] opc;
  logic [2:0] f3_id;
  logic       b30;
  logic [3:0] alu_fn;
  idex_t      dec;
  logic [2:0] imm_sel;
  logic       jal_id;

  assign opc   = instruct[6:0];
  assign f3_id = instruct[14:12];
  assign b30   = instruct[30];

  always_comb begin
    alu_fn = 4'd0;
    case (f3_id)
      3'b000: alu_fn = (opc == OP_REG && b30) ? 4'd1 : 4'd0;
      3'b001: alu_fn = 4'd7;
      3'b010: alu_fn = 4'd5;
      3'b011: alu_fn = 4'd6;
      3'b100: alu_fn = 4'd4;
      3'b101: alu_fn = b30 ? 4'd9 : 4'd8;
      3'b110: alu_fn = 4'd3;
      default: alu_fn = 4'd2;
    endcase
  end

  always_comb begin
    dec     = '0;
    imm_sel = 3'd0;
    jal_id  = 1'b0;
    dec.rs1 = instruct[19:15];
    dec.rs2 = instruct[24:20];
    case (opc)
      OP_LUI: begin
        dec = '{wen:1'b1, wbsel:2'd1, f3:f3_id, bsel:1'b1,
                alu:4'd10, rs1:dec.rs1, rs2:dec.rs2, default:'0};
        imm_sel = 3'd3;
      end
      OP_AUI: begin
        dec = '{wen:1'b1, wbsel:2'd1, f3:f3_id, asel:1'b1,
                bsel:1'b1, rs1:dec.rs1, rs2:dec.rs2, default:'0};
        imm_sel = 3'd3;
      end
      OP_JAL: begin
        dec = '{wen:1'b1, wbsel:2'd2, is_jmp:1'b1, f3:f3_id,
                asel:1'b1, bsel:1'b1, rs1:dec.rs1, rs2:dec.rs2,
                default:'0};
        imm_sel = 3'd4;
        jal_id  = 1'b1;
      end
      OP_JLR: begin
        dec = '{wen:1'b1, wbsel:2'd2, is_jmp:1'b1, f3:f3_id,
                bsel:1'b1, uses:2'b01, rs1:dec.rs1, rs2:dec.rs2,
                default:'0};
      end
      OP_BR: begin
        dec = '{wbsel:2'd1, is_br:1'b1, f3:f3_id, bsign:!f3_id[1],
                asel:1'b1, bsel:1'b1, uses:2'b11, rs1:dec.rs1,
                rs2:dec.rs2, default:'0};
        imm_sel = 3'd2;
      end
      OP_LD: begin
        dec = '{wen:1'b1, f3:f3_id, bsel:1'b1, uses:2'b01,
                rs1:dec.rs1, rs2:dec.rs2, default:'0};
      end
      OP_ST: begin
        dec = '{wbsel:2'd1, dmemrw:1'b1, f3:f3_id, bsel:1'b1,
                uses:2'b11, rs1:dec.rs1, rs2:dec.rs2, default:'0};
        imm_sel = 3'd1;
      end
      OP_IMM: begin
        dec = '{wen:1'b1, wbsel:2'd1, f3:f3_id, bsel:1'b1,
                alu:alu_fn, uses:2'b01, rs1:dec.rs1, rs2:dec.rs2,
                default:'0};
      end
      OP_REG: begin
        dec = '{wen:1'b1, wbsel:2'd1, f3:f3_id, alu:alu_fn,
                uses:2'b11, rs1:dec.rs1, rs2:dec.rs2, default:'0};
        imm_sel = 3'd5;
      end
      default: dec = '0;
    endcase
  end

  assign jump_early   = jal_id;
  assign branch_early = dec.is_br;
  assign imm_gen_sel  = imm_sel;
  assign Reg_WBSelID  = dec.wbsel;

  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   hold, flush, stall;

  assign stall = hazard_signal[0];
  assign flush = hazard_signal[1];
  assign hold  = hazard_signal[2];

  always_comb begin
    idex_d  = dec;
    exmem_d = '{wen:idex_q.wen, wbsel:idex_q.wbsel,
                dmemrw:idex_q.dmemrw, is_br:idex_q.is_br,
                is_jmp:idex_q.is_jmp, f3:idex_q.f3, eq:brEq, lt:brLt};
    memwb_d = '{wen:exmem_q.wen, wbsel:exmem_q.wbsel};
    if (hold) begin
      idex_d  = idex_q;
      exmem_d = exmem_q;
      memwb_d = memwb_q;
    end else if (flush) begin
      idex_d  = '0;
      exmem_d = '0;
    end else if (stall) begin
      idex_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign Reg_WBSelEX   = idex_q.wbsel;
  assign EXmemRead     = idex_q.wen && (idex_q.wbsel == 2'd0);
  assign branch_signed = idex_q.bsign;
  assign ALU_ASel      = idex_q.asel;
  assign ALU_BSel      = idex_q.bsel;
  assign ALU_Sel       = idex_q.alu;
  assign funct3        = exmem_q.f3;
  assign dmemRW        = exmem_q.dmemrw;
  assign Reg_WEn       = memwb_q.wen;
  assign Reg_WBSel     = memwb_q.wbsel;

  logic [4:0] rs1_ex, rs2_ex;
  logic [1:0] sel1, sel2;

  assign rs1_ex = idex_q.uses[0] ? idex_q.rs1 : 5'd0;
  assign rs2_ex = idex_q.uses[1] ? idex_q.rs2 : 5'd0;

  // 10 = from MEM, 01 = from WB; the younger MEM result wins.
  always_comb begin
    sel1 = 2'b00;
    sel2 = 2'b00;
    if (exmem_q.wen && MEMrd != 5'd0 && MEMrd == rs1_ex)
      sel1 = 2'b10;
    else if (memwb_q.wen && WBrd != 5'd0 && WBrd == rs1_ex)
      sel1 = 2'b01;
    if (exmem_q.wen && MEMrd != 5'd0 && MEMrd == rs2_ex)
      sel2 = 2'b10;
    else if (memwb_q.wen && WBrd != 5'd0 && WBrd == rs2_ex)
      sel2 = 2'b01;
  end

  always_comb begin
    forwardA       = 2'b00;
    forwardB       = 2'b00;
    forwardDmem    = 2'b00;
    forwardBranchA = 2'b00;
    forwardBranchB = 2'b00;
    if (idex_q.is_br) begin
      forwardBranchA = sel1;
      forwardBranchB = sel2;
    end else begin
      forwardA = sel1;
      if (idex_q.dmemrw) forwardDmem = sel2;
      else               forwardB    = sel2;
    end
  end

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (exmem_q.f3)
      3'b000: taken = exmem_q.eq;
      3'b001: taken = !exmem_q.eq;
      3'b100: taken = exmem_q.lt;
      3'b101: taken = !exmem_q.lt;
      3'b110: taken = exmem_q.lt;
      3'b111: taken = !exmem_q.lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    PCSel           = 1'b0;
    branch_resolved = 1'b0;
    actual_taken    = 1'b0;
    mispredict      = 1'b0;
    if (exmem_q.is_jmp) begin
      PCSel = !jump_taken;
    end else if (exmem_q.is_br) begin
      branch_resolved = 1'b1;
      actual_taken    = taken;
      PCSel           = taken ^ jump_taken;
      mispredict      = jump_taken && !taken;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{instruct[31], instruct[29:25],
                         instruct[11:7], hazard_signal[3]};

endmodule

// File: tb/tb_rv_ctrl_pipeline.sv
// Directed bench for rv_ctrl_pipeline: per-instruction decode table walked
// through every stage, then hand sequences for forwarding, resolution, hazards.
module tb_rv_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruct;
  logic        brEq, brLt;
  logic [4:0]  MEMrd, WBrd;
  logic        jump_taken;
  logic [3:0]  hazard_signal;
  logic        jump_early, branch_early;
  logic [2:0]  imm_gen_sel;
  logic [1:0]  Reg_WBSelID, Reg_WBSelEX;
  logic        EXmemRead, branch_signed, ALU_ASel, ALU_BSel;
  logic [3:0]  ALU_Sel;
  logic [2:0]  funct3;
  logic        dmemRW, Reg_WEn;
  logic [1:0]  Reg_WBSel;
  logic [1:0]  forwardA, forwardB, forwardDmem;
  logic [1:0]  forwardBranchA, forwardBranchB;
  logic        PCSel, branch_resolved, actual_taken, mispredict;

  always #5 clk = ~clk;

  rv_ctrl_pipeline dut (
    .clk(clk), .rst(rst), .instruct(instruct),
    .brEq(brEq), .brLt(brLt), .MEMrd(MEMrd), .WBrd(WBrd),
    .jump_taken(jump_taken), .hazard_signal(hazard_signal),
    .jump_early(jump_early), .branch_early(branch_early),
    .imm_gen_sel(imm_gen_sel), .Reg_WBSelID(Reg_WBSelID),
    .Reg_WBSelEX(Reg_WBSelEX), .EXmemRead(EXmemRead),
    .branch_signed(branch_signed), .ALU_ASel(ALU_ASel),
    .ALU_BSel(ALU_BSel), .ALU_Sel(ALU_Sel), .funct3(funct3),
    .dmemRW(dmemRW), .Reg_WEn(Reg_WEn), .Reg_WBSel(Reg_WBSel),
    .forwardA(forwardA), .forwardB(forwardB),
    .forwardDmem(forwardDmem), .forwardBranchA(forwardBranchA),
    .forwardBranchB(forwardBranchB), .PCSel(PCSel),
    .branch_resolved(branch_resolved), .actual_taken(actual_taken),
    .mispredict(mispredict)
  );

  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] ADD4  = 32'h00318233;
  localparam logic [31:0] ADDZ  = 32'h000001B3;
  localparam logic [31:0] SW    = 32'h0032A023;
  localparam logic [31:0] LW    = 32'h0000A283;
  localparam logic [31:0] BEQ   = 32'h00208063;
  localparam logic [31:0] JAL   = 32'h000000EF;

  typedef struct {
    logic [31:0] instr;
    logic        je, be;
    logic [2:0]  imm;
    logic [1:0]  wbid;
    logic [3:0]  alu;
    logic        as, bsl, bs, emr, drw;
    logic [2:0]  f3;
    logic        wen;
    logic [1:0]  wb;
  } vec_t;

  vec_t vecs[15];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    logic [31:0] i, logic je, logic be, logic [2:0] imm, logic [1:0] wbid,
    logic [3:0] alu, logic as, logic bsl, logic bs, logic emr, logic drw,
    logic [2:0] f3, logic wen, logic [1:0] wb);
    vec_t v;
    v.instr = i; v.je = je; v.be = be; v.imm = imm; v.wbid = wbid;
    v.alu = alu; v.as = as; v.bsl = bsl; v.bs = bs; v.emr = emr;
    v.drw = drw; v.f3 = f3; v.wen = wen; v.wb = wb;
    return v;
  endfunction

  initial begin
    //             instr        je be imm wbid alu as bB bs emr drw f3 wen wb
    vecs[0]  = mk(ADD3,         0, 0, 5, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[1]  = mk(32'h403100B3, 0, 0, 5, 1,  1, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[2]  = mk(32'h003130B3, 0, 0, 5, 1,  6, 0, 0, 0, 0, 0, 3, 1, 1);
    vecs[3]  = mk(32'h40315093, 0, 0, 0, 1,  9, 0, 1, 0, 0, 0, 5, 1, 1);
    vecs[4]  = mk(32'h00517093, 0, 0, 0, 1,  2, 0, 1, 0, 0, 0, 7, 1, 1);
    vecs[5]  = mk(LW,           0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 2, 1, 0);
    vecs[6]  = mk(SW,           0, 0, 1, 1,  0, 0, 1, 0, 0, 1, 2, 0, 1);
    vecs[7]  = mk(32'h123452B7, 0, 0, 3, 1, 10, 0, 1, 0, 0, 0, 5, 1, 1);
    vecs[8]  = mk(32'h00001317, 0, 0, 3, 1,  0, 1, 1, 0, 0, 0, 1, 1, 1);
    vecs[9]  = mk(JAL,          1, 0, 4, 2,  0, 1, 1, 0, 0, 0, 0, 1, 2);
    vecs[10] = mk(32'h000100E7, 0, 0, 0, 2,  0, 0, 1, 0, 0, 0, 0, 1, 2);
    vecs[11] = mk(BEQ,          0, 1, 2, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
    vecs[12] = mk(32'h0020C063, 0, 1, 2, 1,  0, 1, 1, 1, 0, 0, 4, 0, 1);
    vecs[13] = mk(32'h0020F063, 0, 1, 2, 1,  0, 1, 1, 0, 0, 0, 7, 0, 1);
    vecs[14] = mk(32'hFFFFFFFF, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; instruct = 32'h0; brEq = 0; brLt = 0;
    MEMrd = 0; WBrd = 0; jump_taken = 0; hazard_signal = 4'h0;
    #2;
    check("rst_wen", Reg_WEn, 0);
    check("rst_wbsel", Reg_WBSel, 0);
    check("rst_emr", EXmemRead, 0);
    check("rst_pcsel", PCSel, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      instruct = vecs[i].instr;
      #1;
      check($sformatf("v%0d_je", i), jump_early, vecs[i].je);
      check($sformatf("v%0d_be", i), branch_early, vecs[i].be);
      check($sformatf("v%0d_imm", i), imm_gen_sel, vecs[i].imm);
      check($sformatf("v%0d_wbid", i), Reg_WBSelID, vecs[i].wbid);
      tick();
      instruct = 32'h0;
      check($sformatf("v%0d_alu", i), ALU_Sel, vecs[i].alu);
      check($sformatf("v%0d_asel", i), ALU_ASel, vecs[i].as);
      check($sformatf("v%0d_bsel", i), ALU_BSel, vecs[i].bsl);
      check($sformatf("v%0d_bsign", i), branch_signed, vecs[i].bs);
      check($sformatf("v%0d_emr", i), EXmemRead, vecs[i].emr);
      check($sformatf("v%0d_wbex", i), Reg_WBSelEX, vecs[i].wbid);
      tick();
      check($sformatf("v%0d_drw", i), dmemRW, vecs[i].drw);
      check($sformatf("v%0d_f3", i), funct3, vecs[i].f3);
      tick();
      check($sformatf("v%0d_wen", i), Reg_WEn, vecs[i].wen);
      check($sformatf("v%0d_wb", i), Reg_WBSel, vecs[i].wb);
    end

    // dependent add pair: MEM, then WB, then priority, then no match
    instruct = ADD3; tick();
    instruct = ADD4; tick();
    MEMrd = 3; WBrd = 0; #1;
    check("fwdA_mem", forwardA, 2'b10);
    check("fwdB_mem", forwardB, 2'b10);
    check("fwdDm_mem", forwardDmem, 2'b00);
    tick();
    MEMrd = 0; WBrd = 3; #1;
    check("fwdA_wb", forwardA, 2'b01);
    check("fwdB_wb", forwardB, 2'b01);
    MEMrd = 3; #1;
    check("fwdA_prio", forwardA, 2'b10);
    MEMrd = 0; WBrd = 0; #1;
    check("fwdA_none", forwardA, 2'b00);

    instruct = SW; tick();
    MEMrd = 3; #1;
    check("st_fwdDm", forwardDmem, 2'b10);
    check("st_fwdB", forwardB, 2'b00);
    check("st_fwdA", forwardA, 2'b00);
    MEMrd = 0; WBrd = 5; #1;
    check("st_fwdA_wb", forwardA, 2'b01);
    check("st_fwdDm0", forwardDmem, 2'b00);

    instruct = ADDZ; tick();
    MEMrd = 0; WBrd = 0; #1;
    check("x0_fwdA", forwardA, 2'b00);
    check("x0_fwdB", forwardB, 2'b00);

    instruct = BEQ; tick();
    MEMrd = 1; WBrd = 2; brEq = 1; #1;
    check("br_fwdBA", forwardBranchA, 2'b10);
    check("br_fwdBB", forwardBranchB, 2'b00);
    check("br_fwdA", forwardA, 2'b00);
    instruct = 32'h0; tick();
    MEMrd = 0; WBrd = 0; brEq = 0;
    check("beq_pcsel", PCSel, 1);
    check("beq_res", branch_resolved, 1);
    check("beq_act", actual_taken, 1);
    check("beq_misp", mispredict, 0);
    jump_taken = 1; #1;
    check("beq_pred_pcsel", PCSel, 0);
    check("beq_pred_misp", mispredict, 0);

    jump_taken = 0; instruct = BEQ; tick();
    instruct = 32'h0; tick();
    jump_taken = 1; #1;
    check("bnt_pcsel", PCSel, 1);
    check("bnt_misp", mispredict, 1);
    check("bnt_act", actual_taken, 0);
    check("bnt_res", branch_resolved, 1);

    jump_taken = 0; instruct = JAL; tick();
    instruct = 32'h0; tick();
    jump_taken = 1; #1;
    check("jal_pcsel", PCSel, 0);
    check("jal_res", branch_resolved, 0);
    check("jal_misp", mispredict, 0);
    jump_taken = 0; #1;
    check("jal_np_pcsel", PCSel, 1);

    instruct = ADD3; tick();
    instruct = LW; tick();
    check("fl_pre_emr", EXmemRead, 1);
    hazard_signal = 4'b0010; tick();
    check("fl_emr", EXmemRead, 0);
    check("fl_f3", funct3, 0);
    check("fl_wen", Reg_WEn, 1);
    check("fl_wb", Reg_WBSel, 1);
    hazard_signal = 4'b0000;

    instruct = ADD3; tick();
    instruct = SW; tick();
    instruct = LW; tick();
    instruct = JAL; hazard_signal = 4'b0101; tick();
    check("hold_emr", EXmemRead, 1);
    check("hold_drw", dmemRW, 1);
    check("hold_f3", funct3, 2);
    check("hold_wen", Reg_WEn, 1);
    check("hold_wb", Reg_WBSel, 1);
    hazard_signal = 4'b0001; tick();
    check("stall_emr", EXmemRead, 0);
    check("stall_bsel", ALU_BSel, 0);
    check("stall_drw", dmemRW, 0);
    check("stall_f3", funct3, 2);
    check("stall_wen", Reg_WEn, 0);
    check("stall_wb", Reg_WBSel, 1);
    hazard_signal = 4'b0000;

    #3 rst = 1'b1;
    #1;
    check("arst_f3", funct3, 0);
    check("arst_wb", Reg_WBSel, 0);
    check("arst_alu", ALU_Sel, 0);
    check("arst_pcsel", PCSel, 0);
    check("arst_fwdA", forwardA, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
